// File: rtl/block_mem_pkg.sv
// Shared types and constants for the block-memory arbiter: FSM states,
// requester id, block type and the latency counter width.
package block_mem_pkg;

  localparam int BLK_DATA_WIDTH = 32;
  localparam int BLK_BLOCK_SIZE = 3;
  localparam int BLK_WORDS      = 2 ** BLK_BLOCK_SIZE;
  localparam int CNT_WIDTH      = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef logic req_id_t;

  typedef logic [BLK_WORDS-1:0][BLK_DATA_WIDTH-1:0] block_t;

endpackage

// File: rtl/block_mem_arbiter_rr.sv
// Combinational two-way round-robin: a lone requester wins, a tie goes to
// the requester that was not granted last. Grant is one-hot or zero.
module rr_arbiter2
  import block_mem_pkg::*;
(
  input  logic [1:0] req_valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req_valid;
    if (&req_valid) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/block_mem_arbiter.sv
// Arbiter/sequencer sharing one block-wide data memory between the I-cache
// refill port (0) and the D-cache refill/write-through port (1).
module block_mem_arbiter
  import block_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = BLK_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = BLK_BLOCK_SIZE,
  parameter int MEM_LATENCY   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [1:0]                                req_valid,
  input  logic [1:0]                                req_write,
  input  logic [1:0][ADDRESS_WIDTH-1:0]             req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]                req_wdata,
  output logic [1:0]                                req_ready,
  output logic [1:0]                                resp_valid,
  output logic [(2**BLOCK_SIZE)-1:0][DATA_WIDTH-1:0] resp_block,
  output logic [ADDRESS_WIDTH-1:0]                  mem_address,
  output logic [DATA_WIDTH-1:0]                     mem_write_data,
  output logic                                      mem_write_enable,
  input  logic [(2**BLOCK_SIZE)-1:0][DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

  state_t                   state;
  state_t                   state_next;
  logic [CNT_WIDTH-1:0]     cnt;
  req_id_t                  last_grant;
  req_id_t                  lat_id;
  req_id_t                  grant_id;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic                     lat_write;
  logic [1:0]               grant;
  logic                     accept;
  logic                     last_busy;

  rr_arbiter2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign grant_id  = grant[1];
  assign accept    = |(req_valid & req_ready);
  assign last_busy = (state == BUSY) && (cnt == '0);

  // Ready is gated by rst_n so nothing looks granted while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state == IDLE)) begin
      req_ready = grant;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_busy) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side outputs decode from registered state only, so an async
  // reset drops the write strobe immediately.
  always_comb begin
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    resp_valid       = 2'b00;
    if (state != IDLE) begin
      mem_address = lat_addr;
    end
    if (last_busy && lat_write) begin
      mem_write_enable = 1'b1;
      mem_write_data   = lat_wdata;
    end
    if (state == RESP) begin
      resp_valid[lat_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
      resp_block <= '0;
    end else begin
      if ((state == IDLE) && accept) begin
        lat_id     <= grant_id;
        last_grant <= grant_id;
        lat_addr   <= req_addr[grant_id];
        lat_wdata  <= req_wdata[grant_id];
        lat_write  <= req_write[grant_id];
        cnt        <= CNT_LOAD;
      end else if (state == BUSY) begin
        // Memory writes on negedge, so a write's block already holds the new word here.
        if (cnt == '0) begin
          resp_block <= mem_read_data;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Scoreboard bench for block_mem_arbiter: a 256-word negedge-write memory
// model, a reference memory, and a second instance with MEM_LATENCY=1.
module tb_block_mem_arbiter;
  import block_mem_pkg::*;

  localparam int LAT = 4;

  typedef struct {
    logic [1:0]  onehot;
    block_t      blk;
    int          cyc;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   nerr = 0;
  int   nchk = 0;

  logic [1:0]        req_valid, req_write, req_ready, resp_valid;
  logic [1:0][29:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  block_t            resp_block, mem_rd;
  logic [29:0]       mem_address;
  logic [31:0]       mem_write_data;
  logic              mem_write_enable;

  logic [1:0]        v_l1, w_l1, rdy_l1, rv_l1;
  logic [1:0][29:0]  a_l1;
  logic [1:0][31:0]  d_l1;
  block_t            blk_l1, rd_l1;
  logic [29:0]       maddr_l1;
  logic [31:0]       mwd_l1;
  logic              mwe_l1;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  bit          mem_init = 0;
  bit          ref_init = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  block_t      last_blk;
  int          we_cyc = -1;
  logic [29:0] we_addr;
  logic [31:0] we_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  block_mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30), .BLOCK_SIZE(3), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_block(resp_block), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_rd)
  );

  block_mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30), .BLOCK_SIZE(3), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v_l1), .req_write(w_l1),
    .req_addr(a_l1), .req_wdata(d_l1), .req_ready(rdy_l1),
    .resp_valid(rv_l1), .resp_block(blk_l1), .mem_address(maddr_l1),
    .mem_write_data(mwd_l1), .mem_write_enable(mwe_l1),
    .mem_read_data(rd_l1)
  );

  function automatic logic [31:0] initWord(input int i);
    if (i >= 16 && i < 24) return 32'h20 + 32'(i - 16);
    return 32'h1000_0000 + 32'(i);
  endfunction

  // Memory model: combinational block read, word write on negedge.
  always_comb begin
    for (int w = 0; w < 8; w++) begin
      mem_rd[w] = mem[int'(mem_address[7:3]) * 8 + w];
      rd_l1[w]  = mem[int'(maddr_l1[7:3]) * 8 + w];
    end
  end

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= initWord(i);
      mem_init <= 1'b1;
    end else if (mem_write_enable) begin
      mem[mem_address[7:0]] <= mem_write_data;
    end
  end

  function automatic block_t refBlock(input logic [29:0] a, input logic wr, input logic [31:0] wd);
    block_t b;
    for (int w = 0; w < 8; w++) b[w] = ref_mem[int'(a[7:3]) * 8 + w];
    if (wr) b[a[2:0]] = wd;
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: push on handshake, pop and compare on resp_valid.
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = initWord(i);
      ref_init = 1'b1;
    end
    if (!rst_n) begin
      sb.delete();
      we_cyc = -1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_e.onehot = 2'b01 << i;
          mon_e.blk    = refBlock(req_addr[i], req_write[i], req_wdata[i]);
          mon_e.cyc    = cyc + LAT + 1;
          mon_e.wr     = req_write[i];
          mon_e.addr   = req_addr[i];
          mon_e.data   = req_wdata[i];
          sb.push_back(mon_e);
          if (req_write[i]) begin
            we_cyc  = cyc + LAT;
            we_addr = req_addr[i];
            we_data = req_wdata[i];
          end
        end
      end
      checkOutput("we_cycle", mem_write_enable, cyc == we_cyc);
      if (mem_write_enable) begin
        checkOutput("we_addr", mem_address, we_addr);
        checkOutput("we_data", mem_write_data, we_data);
      end
      if (resp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", resp_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("resp_id", resp_valid, mon_e.onehot);
          checkOutput("resp_block", resp_block, mon_e.blk);
          checkOutput("resp_cycle", cyc, mon_e.cyc);
          last_blk = mon_e.blk;
          if (mon_e.wr) ref_mem[mon_e.addr[7:0]] = mon_e.data;
        end
      end
    end
  end

  task automatic applyStimulus(input int id, input logic wr, input logic [29:0] a, input logic [31:0] d);
    bit got = 1'b0;
    req_write[id] = wr;
    req_addr[id]  = a;
    req_wdata[id] = d;
    req_valid[id] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    checkOutput("grant_seen", got, 1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    #1 checkOutput("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [29:0] l1_addrs [4];
  logic [1:0]  exp_rdy;

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    v_l1 = '0; w_l1 = '0; a_l1 = '0; d_l1 = '0;
    l1_addrs[0] = 30'h12; l1_addrs[1] = 30'h31; l1_addrs[2] = 30'h45; l1_addrs[3] = 30'h07;

    // Reset values, with both requesters asserting valid.
    repeat (3) @(posedge clk);
    #1 req_valid = 2'b11;
    #1;
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_block", resp_block, 0);
    checkOutput("rst_mem_address", mem_address, 0);
    checkOutput("rst_we", mem_write_enable, 0);
    checkOutput("rst_wdata", mem_write_data, 0);
    checkOutput("rst_l1_resp_valid", rv_l1, 0);
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read, write-through, read-back of the written block.
    applyStimulus(0, 1'b0, 30'h12, 32'h0);
    waitIdle();
    @(negedge clk);
    checkOutput("resp_hold", resp_block, last_blk);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b1, 30'h13, 32'hDEAD_BEEF);
    waitIdle();
    checkOutput("wr_mem", mem[8'h13], 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 30'h10, 32'h0);
    waitIdle();
    applyStimulus(0, 1'b1, 30'h2A, 32'h1234_5678);
    waitIdle();
    applyStimulus(1, 1'b0, 30'h2F, 32'h0);
    waitIdle();

    // Tie from reset with both valid held: grants alternate 0,1,0,1 every 6 cycles.
    resetDut();
    req_write = 2'b00;
    req_addr[0] = 30'h08;
    req_addr[1] = 30'h18;
    req_valid = 2'b11;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      exp_rdy = 2'b00;
      if (k % 6 == 0) exp_rdy = ((k / 6) % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput("tie_ready", req_ready, exp_rdy);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    waitIdle();

    // Requester 1 raises valid during requester 0's transaction and waits.
    req_addr[0] = 30'h20;
    req_addr[1] = 30'h3B;
    req_valid = 2'b01;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp_rdy = (k == 0) ? 2'b01 : (k == 6) ? 2'b10 : 2'b00;
      checkOutput("held_ready", req_ready, exp_rdy);
      if (k == 0) begin
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
      end
      if (k == 1) req_valid[1] = 1'b1;
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    waitIdle();

    // MEM_LATENCY=1 instance: back-to-back reads complete every 3 cycles.
    a_l1[0] = l1_addrs[0];
    v_l1 = 2'b01;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("l1_ready", rdy_l1, (k % 3 == 0) ? 2'b01 : 2'b00);
      checkOutput("l1_resp_valid", rv_l1, (k % 3 == 2) ? 2'b01 : 2'b00);
      if (k % 3 == 1) checkOutput("l1_addr", maddr_l1, l1_addrs[k / 3]);
      if (k % 3 == 2) checkOutput("l1_block", blk_l1, refBlock(l1_addrs[k / 3], 1'b0, 32'h0));
      if (k % 3 == 0) begin
        @(posedge clk);
        #1;
        if (k / 3 < 3) a_l1[0] = l1_addrs[k / 3 + 1];
        else v_l1 = 2'b00;
      end
    end
    @(posedge clk);
    #1;

    // Reset during BUSY of a write to 0x10 aborts it.
    applyStimulus(0, 1'b1, 30'h10, 32'hCAFE_F00D);
    @(posedge clk);
    #1 checkOutput("abort_addr_before", mem_address, 30'h10);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_addr", mem_address, 0);
    checkOutput("abort_we", mem_write_enable, 0);
    checkOutput("abort_wdata", mem_write_data, 0);
    checkOutput("abort_resp_valid", resp_valid, 0);
    checkOutput("abort_block", resp_block, 0);
    req_valid = 2'b10;
    #1 checkOutput("abort_ready", req_ready, 0);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1 checkOutput("abort_mem", mem[8'h10], 32'h20);
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
